simpson_aux_unit: RTL and testbench
===================================

Name: simpson_aux_unit

Overview:
- Support block for the Simpson's-rule integrator top-level FSM. It bundles three functions:
  - a button debouncer that emits one press pulse per physical press;
  - a clock-enable divider that paces the seven-segment display scan;
  - three parallel evaluators for the cubic polynomial at three abscissas.
- The FSM uses the press pulse to step through coefficient and limit entry.
- It sums the polynomial values to accumulate the integral.

Parameters:
- DIV_CYCLES, 100000: period of disp_ce in clk cycles (1 kHz at 100 MHz); legal range >= 2.
- DEBOUNCE_CYCLES, 1000000: number of consecutive cycles the synchronized button must differ from the accepted level before the new level is accepted (10 ms at 100 MHz); legal range >= 1.

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- btn  in  1  raw, asynchronous, bouncing push-button level.
- press  out  1  one-cycle pulse per debounced 0->1 button transition.
- disp_ce  out  1  one-cycle clock-enable pulse every DIV_CYCLES cycles.
- a0  in  16  constant coefficient.
- a1  in  16  linear coefficient.
- a2  in  16  quadratic coefficient.
- a3  in  16  cubic coefficient.
- x1, x2, x3  in  16 each  evaluation points.
- y1, y2, y3  out  16 each  polynomial value at x1, x2, x3 respectively.

Behaviour:
- Reset, sampled on the clk edge while rst_n=0:
  - synchronizer flops, accepted button level and debounce counter clear to 0;
  - press=0;
  - divider counter clears to 0 and disp_ce=0.
  - y1..y3 are combinational and not affected by reset.
- Debouncer:
  - btn passes through a 2-flop synchronizer; the synchronized level is btn_s.
  - While btn_s equals the accepted level, the counter holds at 0.
  - While btn_s differs, the counter increments by 1 per cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 and btn_s still differs on that cycle, the accepted level takes btn_s and the counter clears.
  - Any return of btn_s to the accepted level before then clears the counter; bounces restart the count.
  - press is registered and is 1 for exactly the one cycle following the accepted level changing 0->1.
  - A 1->0 acceptance produces no pulse.
  - Holding the button produces no further pulses.
  - Worst-case latency from a clean btn edge to press=1 is 2 sync cycles + DEBOUNCE_CYCLES + 1 cycles.
- Divider:
  - The counter runs 0..DIV_CYCLES-1 and wraps to 0.
  - disp_ce is registered and is 1 for exactly one cycle each time the counter wraps.
  - The first pulse occurs DIV_CYCLES cycles after rst_n deasserts; thereafter the period is exactly DIV_CYCLES.
- Evaluators:
  - Purely combinational, zero latency.
  - Each output is yk = a0 + a1*xk + a2*xk^2 + a3*xk^3.
  - All operands are unsigned; every product and sum is truncated modulo 2^16.
  - Horner form (((a3*x + a2)*x + a1)*x + a0) with 16-bit truncation at each step is required; it is bit-identical modulo 2^16.
  - No overflow flag. The three channels share coefficients and are otherwise independent.
- Reset asserted mid-debounce or mid-divide:
  - all counts are abandoned;
  - no press or disp_ce pulse is emitted in the reset cycle or the cycle after.

Test Plan:
- Divider: DIV_CYCLES=4, release reset -> disp_ce=1 on cycles 4, 8, 12 after release, 0 on all other cycles; assert rst_n=0 at cycle 6 -> next pulse 4 cycles after re-release.
- Debounce clean press: DEBOUNCE_CYCLES=8, btn held 1 for 40 cycles -> exactly one press pulse, one cycle wide, 11 cycles after the btn edge; release -> no pulse.
- Bounce rejection: DEBOUNCE_CYCLES=8, btn toggles 1 for 5 cycles / 0 for 2 cycles three times, then steady 1 -> single press only after 8 steady cycles.
- Short glitch: btn=1 for 3 cycles then 0 (DEBOUNCE_CYCLES=8) -> no press pulse ever.
- Polynomial values:
  - a0=1, a1=2, a2=3, a3=4 with x1=0, x2=1, x3=2 -> y1=1, y2=10, y3=49;
  - a3=1, others 0, x=100 -> y=1000000 mod 65536=16960;
  - all coefficients 0xFFFF, x=1 -> y=0xFFFC.
- Channel independence: change only x2 from 3 to 5 with a0=0, a1=1, a2=0, a3=0 -> y2 goes 3->5 in the same cycle; y1 and y3 unchanged.

Source files
------------

// File: rtl/simpson_aux_unit.sv
// simpson_aux_unit: button debouncer, display clock-enable divider and three cubic evaluators
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   btn                 raw bouncing push-button level (asynchronous)
//   press               one-cycle pulse per debounced 0->1 press
//   disp_ce             one-cycle enable every DIV_CYCLES cycles
//   a0..a3              shared cubic coefficients (constant .. cubic term)
//   x1..x3 / y1..y3     evaluation points and combinational polynomial values
module simpson_aux_unit #(
  parameter int DIV_CYCLES      = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn,
  output logic        press,
  output logic        disp_ce,
  input  logic [15:0] a0,
  input  logic [15:0] a1,
  input  logic [15:0] a2,
  input  logic [15:0] a3,
  input  logic [15:0] x1,
  input  logic [15:0] x2,
  input  logic [15:0] x3,
  output logic [15:0] y1,
  output logic [15:0] y2,
  output logic [15:0] y3
);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DVW = $clog2(DIV_CYCLES);
  localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DVW-1:0] DV_MAX = DVW'(DIV_CYCLES - 1);

  logic [1:0]     r_sync;
  logic           r_lvl;
  logic           r_lvl_d;
  logic [DBW-1:0] r_cnt;
  logic [DVW-1:0] r_div;
  logic           w_btn_s;

  assign w_btn_s = r_sync[1];

  // Counter only runs while the synchronized level disagrees with the accepted one,
  // so any bounce back to the accepted level restarts the qualification window.
  // press fires the cycle after the accepted level rises.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync  <= 2'b00;
      r_lvl   <= 1'b0;
      r_lvl_d <= 1'b0;
      r_cnt   <= '0;
      press   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], btn};
      r_lvl_d <= r_lvl;
      press   <= r_lvl & ~r_lvl_d;
      if (w_btn_s == r_lvl) r_cnt <= '0;
      else if (r_cnt == DB_MAX) begin
        r_lvl <= w_btn_s;
        r_cnt <= '0;
      end else r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div   <= '0;
      disp_ce <= 1'b0;
    end else begin
      disp_ce <= r_div == DV_MAX;
      r_div   <= (r_div == DV_MAX) ? '0 : r_div + 1'b1;
    end
  end

  // Horner evaluation; every product and sum wraps modulo 2^16.
  function automatic logic [15:0] horner(input logic [15:0] x, c0, c1, c2, c3);
    logic [15:0] t;
    t = c3 * x + c2;
    t = t * x + c1;
    t = t * x + c0;
    return t;
  endfunction

  assign y1 = horner(x1, a0, a1, a2, a3);
  assign y2 = horner(x2, a0, a1, a2, a3);
  assign y3 = horner(x3, a0, a1, a2, a3);
endmodule

// File: tb/tb_simpson_aux_unit.sv
// tb_simpson_aux_unit: scoreboard bench for debouncer, divider and cubic evaluators
module tb_simpson_aux_unit;
  logic clk = 1'b0;
  logic rst_n, btn, press, disp_ce;
  logic [15:0] a0, a1, a2, a3, x1, x2, x3, y1, y2, y3;

  typedef struct {logic [15:0] y1, y2, y3;} exp_t;

  int   pq[$];
  int   cq[$];
  exp_t yq[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic ce_chk = 1'b1;
  logic done = 1'b0;
  logic fin = 1'b0;
  logic exp_p, exp_c;
  exp_t e;

  simpson_aux_unit #(.DIV_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .press(press), .disp_ce(disp_ce),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3),
    .x1(x1), .x2(x2), .x3(x3), .y1(y1), .y2(y2), .y3(y3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (cyc >= 1 && !fin) begin
      exp_p = pq.size() > 0 && pq[0] == cyc;
      total++;
      if (press !== exp_p) begin
        bad++;
        $display("FAIL press cyc=%0d got=%b want=%b", cyc, press, exp_p);
      end
      if (exp_p) void'(pq.pop_front());
      if (ce_chk) begin
        exp_c = cq.size() > 0 && cq[0] == cyc;
        total++;
        if (disp_ce !== exp_c) begin
          bad++;
          $display("FAIL disp_ce cyc=%0d got=%b want=%b", cyc, disp_ce, exp_c);
        end
        if (exp_c) void'(cq.pop_front());
      end
      if (yq.size() > 0) begin
        e = yq.pop_front();
        total += 3;
        if (y1 !== e.y1) begin bad++; $display("FAIL y1 cyc=%0d got=%0d want=%0d", cyc, y1, e.y1); end
        if (y2 !== e.y2) begin bad++; $display("FAIL y2 cyc=%0d got=%0d want=%0d", cyc, y2, e.y2); end
        if (y3 !== e.y3) begin bad++; $display("FAIL y3 cyc=%0d got=%0d want=%0d", cyc, y3, e.y3); end
      end
      if (done) begin
        total++;
        if (pq.size() != 0 || cq.size() != 0) begin
          bad++;
          $display("FAIL leftover press=%0d disp_ce=%0d want=0", pq.size(), cq.size());
        end
        fin = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic poly(input logic [15:0] c0, c1, c2, c3, p1, p2, p3, e1, e2, e3);
    exp_t t;
    a0 = c0; a1 = c1; a2 = c2; a3 = c3;
    x1 = p1; x2 = p2; x3 = p3;
    t.y1 = e1; t.y2 = e2; t.y3 = e3;
    yq.push_back(t);
    tick(1);
  endtask

  int r, c;

  initial begin
    rst_n = 1'b0; btn = 1'b0;
    a0 = 0; a1 = 0; a2 = 0; a3 = 0; x1 = 0; x2 = 0; x3 = 0;
    tick(3);
    rst_n = 1'b1; r = cyc;
    cq.push_back(r + 4); cq.push_back(r + 8); cq.push_back(r + 12);
    poly(16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd1, 16'd2, 16'd1, 16'd10, 16'd49);
    poly(16'd0, 16'd0, 16'd0, 16'd1, 16'd100, 16'd2, 16'd0, 16'd16960, 16'd8, 16'd0);
    poly(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd1, 16'd1, 16'd1, 16'hFFFC, 16'hFFFC, 16'hFFFC);
    poly(16'd5, 16'd1, 16'd1, 16'd0, 16'hFFFF, 16'd3, 16'd256, 16'd5, 16'd17, 16'd261);
    poly(16'd0, 16'd1, 16'd0, 16'd0, 16'd7, 16'd3, 16'd9, 16'd7, 16'd3, 16'd9);
    poly(16'd0, 16'd1, 16'd0, 16'd0, 16'd7, 16'd5, 16'd9, 16'd7, 16'd5, 16'd9);
    tick(6 - (cyc - r));
    rst_n = 1'b0;
    cq.push_back(r + 12);
    void'(cq.pop_back());
    cq.delete();
    tick(2);
    rst_n = 1'b1; r = cyc;
    cq.push_back(r + 4); cq.push_back(r + 8);
    tick(9);
    ce_chk = 1'b0;
    c = cyc; btn = 1'b1; pq.push_back(c + 11);
    tick(40);
    btn = 1'b0;
    tick(20);
    repeat (3) begin
      btn = 1'b1; tick(5);
      btn = 1'b0; tick(2);
    end
    btn = 1'b1; c = cyc; pq.push_back(c + 11);
    tick(30);
    btn = 1'b0;
    tick(20);
    btn = 1'b1; tick(3);
    btn = 1'b0; tick(30);
    done = 1'b1;
    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
